// File: rtl/ray_aabb_hit_collector.sv
// ray_aabb_hit_collector
//
// Sits downstream of the ray/AABB intersection core. Each issued box travels
// through a tag delay line that is as deep as the core latency, so the box id
// arrives at the head in the same cycle as that box's hit_miss bit. Retired
// boxes are accumulated per ray: an any-hit flag, a saturating hit count, and
// the id of the first retired hitting box. Each completed ray is presented on a
// one-entry valid/ready output slot.
//
// Optional feature macro: RAY_AABB_ERROR_COUNT_EN
//   Adds the exp_valid/exp_hit inputs (reference result, aligned with issue)
//   and the type1_err/type2_err saturating mismatch counters.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   issue_valid    a box enters the core this cycle
//   issue_id       id of the issued box
//   issue_last     issued box is the final box of its ray
//   hit_miss       core result; used only when the delay-line head is valid
//   res_valid      per-ray result available
//   res_ready      consumer accepts the result
//   res_hit        at least one box of the ray hit
//   res_count      number of hits, saturating
//   res_first_id   id of the first retired hitting box (0 when no hit)
//   issue_ready    upstream may issue
//   overflow       sticky: a ray completed while the output slot was full
//   exp_valid      (feature) reference bit present for this issue
//   exp_hit        (feature) reference hit bit
//   type1_err      (feature) count of true hits missed by the core
//   type2_err      (feature) count of false hits reported by the core

module ray_aabb_hit_collector #(
    parameter int unsigned LATENCY = 34,
    parameter int unsigned ID_W    = 10,
    parameter int unsigned CNT_W   = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [ID_W-1:0]  issue_id,
    input  logic             issue_last,
    input  logic             hit_miss,
`ifdef RAY_AABB_ERROR_COUNT_EN
    input  logic             exp_valid,
    input  logic             exp_hit,
    output logic [15:0]      type1_err,
    output logic [15:0]      type2_err,
`endif
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_hit,
    output logic [CNT_W-1:0] res_count,
    output logic [ID_W-1:0]  res_first_id,
    output logic             issue_ready,
    output logic             overflow
);

    localparam int unsigned LIF_W = $clog2(LATENCY + 1);

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    // Delay line: stage 0 loads every cycle, head is stage LATENCY-1.
    logic [LATENCY-1:0]           dl_valid;
    logic [LATENCY-1:0]           dl_last;
    logic [LATENCY-1:0][ID_W-1:0] dl_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            dl_valid <= '0;
        end else begin
            dl_valid[0] <= issue_valid;
            for (int i = 1; i < int'(LATENCY); i++) begin
                dl_valid[i] <= dl_valid[i-1];
            end
        end
    end

    // Payload needs no reset; it is only qualified by dl_valid.
    always_ff @(posedge clk) begin
        dl_id[0]   <= issue_id;
        dl_last[0] <= issue_last;
        for (int i = 1; i < int'(LATENCY); i++) begin
            dl_id[i]   <= dl_id[i-1];
            dl_last[i] <= dl_last[i-1];
        end
    end

    logic            head_valid;
    logic            head_last;
    logic [ID_W-1:0] head_id;

    assign head_valid = dl_valid[LATENCY-1];
    assign head_last  = dl_last[LATENCY-1];
    assign head_id    = dl_id[LATENCY-1];

    // Per-ray accumulator FSM.
    state_e           state_q, state_d;
    logic             acc_hit_q, acc_hit_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic [ID_W-1:0]  acc_first_q, acc_first_d;

    // Accumulator values including the head box's contribution.
    logic             upd_hit;
    logic [CNT_W-1:0] upd_cnt;
    logic [ID_W-1:0]  upd_first;
    logic             complete;

    always_comb begin
        upd_hit   = acc_hit_q | hit_miss;
        upd_cnt   = (hit_miss && acc_cnt_q != '1) ? acc_cnt_q + CNT_W'(1) : acc_cnt_q;
        upd_first = (hit_miss && !acc_hit_q) ? head_id : acc_first_q;

        state_d     = state_q;
        acc_hit_d   = acc_hit_q;
        acc_cnt_d   = acc_cnt_q;
        acc_first_d = acc_first_q;
        complete    = 1'b0;

        if (head_valid) begin
            if (head_last) begin
                // Ray finishes: result leaves via upd_*, accumulators restart.
                complete    = 1'b1;
                state_d     = StIdle;
                acc_hit_d   = 1'b0;
                acc_cnt_d   = '0;
                acc_first_d = '0;
            end else begin
                state_d     = StAccum;
                acc_hit_d   = upd_hit;
                acc_cnt_d   = upd_cnt;
                acc_first_d = upd_first;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            acc_hit_q   <= 1'b0;
            acc_cnt_q   <= '0;
            acc_first_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_hit_q   <= acc_hit_d;
            acc_cnt_q   <= acc_cnt_d;
            acc_first_q <= acc_first_d;
        end
    end

    // Output slot: loads when empty or draining this same cycle.
    logic slot_free;
    assign slot_free = !res_valid || res_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid    <= 1'b0;
            res_hit      <= 1'b0;
            res_count    <= '0;
            res_first_id <= '0;
            overflow     <= 1'b0;
        end else if (complete) begin
            if (slot_free) begin
                res_valid    <= 1'b1;
                res_hit      <= upd_hit;
                res_count    <= upd_cnt;
                res_first_id <= upd_first;
            end else begin
                overflow <= 1'b1;
            end
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

    // Number of ray-terminating boxes still inside the core.
    logic [LIF_W-1:0] lasts_in_flight_q;
    logic             lif_inc;
    logic             lif_dec;

    assign lif_inc = issue_valid && issue_last;
    assign lif_dec = head_valid && head_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            lasts_in_flight_q <= '0;
        end else if (lif_inc && !lif_dec) begin
            lasts_in_flight_q <= lasts_in_flight_q + LIF_W'(1);
        end else if (lif_dec && !lif_inc) begin
            lasts_in_flight_q <= lasts_in_flight_q - LIF_W'(1);
        end
    end

    // A full slot plus a pending ray completion would overflow.
    assign issue_ready = !(res_valid && lasts_in_flight_q != '0);

`ifdef RAY_AABB_ERROR_COUNT_EN
    logic [LATENCY-1:0] dl_exp;
    logic [LATENCY-1:0] dl_exp_valid;

    always_ff @(posedge clk) begin
        dl_exp[0]       <= exp_hit;
        dl_exp_valid[0] <= exp_valid;
        for (int i = 1; i < int'(LATENCY); i++) begin
            dl_exp[i]       <= dl_exp[i-1];
            dl_exp_valid[i] <= dl_exp_valid[i-1];
        end
    end

    logic head_exp;
    logic head_exp_valid;
    logic mismatch;

    assign head_exp       = dl_exp[LATENCY-1];
    assign head_exp_valid = dl_exp_valid[LATENCY-1];
    assign mismatch       = head_valid && head_exp_valid && (hit_miss != head_exp);

    always_ff @(posedge clk) begin
        if (rst) begin
            type1_err <= '0;
            type2_err <= '0;
        end else if (mismatch) begin
            if (head_exp) begin
                if (type1_err != '1) type1_err <= type1_err + 16'd1;
            end else begin
                if (type2_err != '1) type2_err <= type2_err + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ray_aabb_hit_collector.sv
module tb_ray_aabb_hit_collector;

    localparam int LAT  = 34;
    localparam int IDW  = 10;
    localparam int CW1  = 11;
    localparam int CW2  = 2;

    logic           clk;
    logic           rst;
    logic           issue_valid;
    logic [IDW-1:0] issue_id;
    logic           issue_last;
    logic           hit_miss;
    logic           res_ready;
    logic           exp_valid;
    logic           exp_hit;

    logic           res_valid, res_hit, issue_ready, overflow;
    logic [CW1-1:0] res_count;
    logic [IDW-1:0] res_first_id;
    logic           res_valid2, res_hit2, issue_ready2, overflow2;
    logic [CW2-1:0] res_count2;
    logic [IDW-1:0] res_first_id2;
`ifdef RAY_AABB_ERROR_COUNT_EN
    logic [15:0]    type1_err, type2_err, type1_err2, type2_err2;
`endif

    ray_aabb_hit_collector #(.LATENCY(LAT), .ID_W(IDW), .CNT_W(CW1)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_id     (issue_id),
        .issue_last   (issue_last),
        .hit_miss     (hit_miss),
`ifdef RAY_AABB_ERROR_COUNT_EN
        .exp_valid    (exp_valid),
        .exp_hit      (exp_hit),
        .type1_err    (type1_err),
        .type2_err    (type2_err),
`endif
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_hit      (res_hit),
        .res_count    (res_count),
        .res_first_id (res_first_id),
        .issue_ready  (issue_ready),
        .overflow     (overflow)
    );

    // Narrow-counter instance fed the same stimulus to exercise saturation.
    ray_aabb_hit_collector #(.LATENCY(LAT), .ID_W(IDW), .CNT_W(CW2)) u_dut2 (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_id     (issue_id),
        .issue_last   (issue_last),
        .hit_miss     (hit_miss),
`ifdef RAY_AABB_ERROR_COUNT_EN
        .exp_valid    (exp_valid),
        .exp_hit      (exp_hit),
        .type1_err    (type1_err2),
        .type2_err    (type2_err2),
`endif
        .res_valid    (res_valid2),
        .res_ready    (res_ready),
        .res_hit      (res_hit2),
        .res_count    (res_count2),
        .res_first_id (res_first_id2),
        .issue_ready  (issue_ready2),
        .overflow     (overflow2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int id;
        bit last;
        int t;
        bit ex;
        bit exv;
    } box_t;

    box_t q[$];
    bit   hm_sched [0:4095];
    int   cyc = 0;
    bit   force_hm = 0;
    bit   issue_hit = 0;

    int m_hits, m_first;
    bit m_any;
    bit m_valid, m_res_any, m_ovf;
    int m_res_hits, m_res_first;
    int m_t1, m_t2;

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic int model_lasts();
        int n;
        n = 0;
        foreach (q[i]) if (q[i].last) n++;
        return n;
    endfunction

    // Applies the rules for one clock edge using the inputs present at it.
    task automatic model_update();
        box_t b;
        bit done;
        if (rst) begin
            q.delete();
            m_hits = 0; m_any = 0; m_first = 0;
            m_valid = 0; m_ovf = 0; m_t1 = 0; m_t2 = 0;
            m_res_any = 0; m_res_hits = 0; m_res_first = 0;
            return;
        end
        done = 0;
        if (q.size() > 0 && q[0].t + LAT == cyc) begin
            b = q.pop_front();
            if (hit_miss) begin
                m_hits++;
                if (!m_any) begin
                    m_any = 1;
                    m_first = b.id;
                end
            end
            if (b.exv && (hit_miss != b.ex)) begin
                if (b.ex) m_t1++;
                else m_t2++;
            end
            if (b.last) begin
                done = 1;
                if (!m_valid || res_ready) begin
                    m_valid = 1;
                    m_res_any = m_any;
                    m_res_hits = m_hits;
                    m_res_first = m_first;
                end else begin
                    m_ovf = 1;
                end
                m_hits = 0; m_any = 0; m_first = 0;
            end
        end
        if (!done && m_valid && res_ready) m_valid = 0;
        if (issue_valid) begin
            q.push_back('{id: int'(issue_id), last: issue_last, t: cyc, ex: exp_hit,
                          exv: exp_valid});
            hm_sched[cyc+LAT] = issue_hit;
        end
    endtask

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("res_valid", 32'(res_valid), 32'(m_valid));
                chk("res_valid2", 32'(res_valid2), 32'(m_valid));
                chk("issue_ready", 32'(issue_ready), 32'(!(m_valid && model_lasts() != 0)));
                chk("overflow", 32'(overflow), 32'(m_ovf));
                if (m_valid) begin
                    chk("res_hit", 32'(res_hit), 32'(m_res_any));
                    chk("res_count", 32'(res_count), sat(m_res_hits, CW1));
                    chk("res_count2", 32'(res_count2), sat(m_res_hits, CW2));
                    chk("res_first_id", 32'(res_first_id), m_res_first);
                    chk("res_first_id2", 32'(res_first_id2), m_res_first);
                end
`ifdef RAY_AABB_ERROR_COUNT_EN
                chk("type1_err", 32'(type1_err), sat(m_t1, 16));
                chk("type2_err", 32'(type2_err), sat(m_t2, 16));
`endif
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        hit_miss = force_hm ? 1'b1 : hm_sched[cyc+1];
        @(posedge clk);
        cyc++;
        model_update();
        #1;
    endtask

    task automatic issue(input int id, input bit last, input bit hit, input bit ex);
        issue_valid = 1'b1;
        issue_id    = IDW'(id);
        issue_last  = last;
        issue_hit   = hit;
        exp_valid   = 1'b1;
        exp_hit     = ex;
        tick();
        issue_valid = 1'b0;
        issue_last  = 1'b0;
        exp_valid   = 1'b0;
        exp_hit     = 1'b0;
    endtask

    int cap_cyc, cap_pulses, cap_hit, cap_cnt, cap_cnt2, cap_first;

    // Bounded wait that records the first result seen and counts valid cycles.
    task automatic wait_result(input int ncyc);
        cap_cyc = -1; cap_pulses = 0;
        cap_hit = -1; cap_cnt = -1; cap_cnt2 = -1; cap_first = -1;
        repeat (ncyc) begin
            tick();
            if (res_valid === 1'b1) begin
                cap_pulses++;
                if (cap_cyc < 0) begin
                    cap_cyc   = cyc;
                    cap_hit   = int'(res_hit);
                    cap_cnt   = int'(res_count);
                    cap_cnt2  = int'(res_count2);
                    cap_first = int'(res_first_id);
                end
            end
        end
    endtask

    int t_last;

    initial begin
        rst = 1'b1; issue_valid = 1'b0; issue_id = '0; issue_last = 1'b0;
        hit_miss = 1'b0; res_ready = 1'b0; exp_valid = 1'b0; exp_hit = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk_en = 1;
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_hit", 32'(res_hit), 0);
        chk("rst_res_count", 32'(res_count), 0);
        chk("rst_res_first_id", 32'(res_first_id), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_issue_ready", 32'(issue_ready), 1);

        // Ray ids 0..3, hits 0,1,0,1.
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) issue(i, i == 3, (i % 2) == 1, 1'b0);
        t_last = cyc;
        wait_result(50);
        chk("t1_latency", cap_cyc, t_last + 34);
        chk("t1_pulses", cap_pulses, 1);
        chk("t1_hit", cap_hit, 1);
        chk("t1_count", cap_cnt, 2);
        chk("t1_first", cap_first, 1);

        // Five-box ray, no hits.
        for (int i = 0; i < 5; i++) issue(10 + i, i == 4, 1'b0, 1'b0);
        wait_result(45);
        chk("t2_pulses", cap_pulses, 1);
        chk("t2_hit", cap_hit, 0);
        chk("t2_count", cap_cnt, 0);
        chk("t2_first", cap_first, 0);

        // Back-to-back single-box rays with the consumer stalled.
        res_ready = 1'b0;
        issue(7, 1'b1, 1'b1, 1'b0);
        chk("t3_ready_before", 32'(issue_ready), 1);
        issue(8, 1'b1, 1'b1, 1'b0);
        t_last = cyc;
        while (cyc < t_last + 33) tick();
        chk("t3_valid_held", 32'(res_valid), 1);
        chk("t3_first_7", 32'(res_first_id), 7);
        chk("t3_ready_blocked", 32'(issue_ready), 0);
        chk("t3_no_ovf_yet", 32'(overflow), 0);
        tick();
        chk("t3_overflow", 32'(overflow), 1);
        chk("t3_still_7", 32'(res_first_id), 7);
        chk("t3_valid_still", 32'(res_valid), 1);
        chk("t3_ready_back", 32'(issue_ready), 1);
        res_ready = 1'b1;
        tick();
        chk("t3_drained", 32'(res_valid), 0);
        chk("t3_ovf_sticky", 32'(overflow), 1);

        // Six hitting boxes: narrow counter saturates.
        for (int i = 0; i < 6; i++) issue(20 + i, i == 5, 1'b1, 1'b0);
        wait_result(45);
        chk("t4_count_wide", cap_cnt, 6);
        chk("t4_count_sat", cap_cnt2, 3);
        chk("t4_first", cap_first, 20);
        chk("t4_hit", cap_hit, 1);

        // Reset mid-ray with the core output forced high.
        for (int i = 0; i < 4; i++) issue(30 + i, i == 3, 1'b1, 1'b0);
        repeat (6) tick();
        force_hm = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_result(50);
        chk("t5_no_result", cap_pulses, 0);
        chk("t5_overflow", 32'(overflow), 0);
        chk("t5_issue_ready", 32'(issue_ready), 1);
        force_hm = 1'b0;

`ifdef RAY_AABB_ERROR_COUNT_EN
        begin
            logic [9:0] exp_pat;
            logic [9:0] core_pat;
            exp_pat  = 10'b1010101010;
            core_pat = 10'b1000001011;
            for (int i = 0; i < 10; i++) issue(40 + i, i == 9, core_pat[9-i], exp_pat[9-i]);
            wait_result(45);
            chk("t6_type1", 32'(type1_err), 2);
            chk("t6_type2", 32'(type2_err), 1);
            chk("t6_count", cap_cnt, 4);
            chk("t6_first", cap_first, 40);
        end
`endif

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ray_aabb_hit_collector.md
Name: ray_aabb_hit_collector

Overview:
- Downstream companion to the ray/AABB intersection pipeline (15-bit flopoco operands, fixed 34-cycle latency, one-bit hit_miss per box).
- Tracks each issued box through a valid/tag delay line matching the core latency and aligns the retiring hit_miss bit with its box id.
- Accumulates per-ray results: hit flag, hit count, first hitting box id.
- Presents one result per ray on a valid/ready output port.

Parameters:
- LATENCY, 34, core cycles from operand capture to hit_miss valid; delay-line depth; legal range 1..64.
- ID_W, 10, width of box id tag.
- CNT_W, 11, width of per-ray hit counter; saturating.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  a box's operands enter the core this cycle.
- issue_id  in  ID_W  id of the issued box.
- issue_last  in  1  the issued box is the final box of the current ray.
- hit_miss  in  1  core output; meaningful only when the delay-line head is valid.
- res_valid  out  1  per-ray result available.
- res_ready  in  1  consumer accepts the result.
- res_hit  out  1  at least one box of the ray hit.
- res_count  out  CNT_W  number of hits, saturating at all-ones.
- res_first_id  out  ID_W  id of the first retired hitting box; 0 when res_hit=0.
- issue_ready  out  1  upstream may issue (see Behaviour).
- overflow  out  1  sticky: a ray completed while the output slot was full.

Behaviour:
- Delay line: LATENCY-stage shift register of {valid, id, last}. Stage 0 loads {issue_valid, issue_id, issue_last} every cycle. Head = stage LATENCY-1. It retires at the cycle whose hit_miss belongs to that box, i.e. a box issued at edge N retires with hit_miss sampled at edge N+LATENCY.
- issue_* are sampled only when issue_valid=1. If issue_ready=0, the collector still captures issue_valid. Issuing while not ready is an upstream protocol violation and is not masked.
- FSM, states IDLE and ACCUM:
  - IDLE: no retired box for the current ray. Accumulators are cleared (hit=0, count=0, first_id=0).
  - IDLE, head valid, last=0 -> ACCUM, accumulating this box.
  - IDLE, head valid, last=1 -> single-box ray: complete immediately, stay IDLE.
  - ACCUM, head valid, last=0 -> accumulate, stay ACCUM.
  - ACCUM, head valid, last=1 -> accumulate, complete, -> IDLE.
  - Head invalid -> no change in either state.
- Accumulate rule when hit_miss=1:
  - count increments, saturating at 2^CNT_W-1.
  - If hit was 0: first_id <= head id and hit <= 1.
- Complete: the result including the last box's contribution loads the output slot.
  - Slot load occurs only if the slot is empty or is being drained the same cycle (res_valid & res_ready). The result then appears with res_valid=1 on the next cycle.
  - Otherwise the result is dropped, overflow is set, and the slot keeps its old contents.
- Output slot: res_valid clears on res_valid & res_ready unless a new result loads the same cycle. A simultaneous drain and load keeps res_valid=1 with the new data.
- issue_ready = !(res_valid && lasts_in_flight != 0), where lasts_in_flight counts last=1 entries in the delay line.
  - Registered count: +1 on issue of a last, -1 on retire of a last; both in the same cycle leave it unchanged.
  - Width ceil(log2(LATENCY+1)).
- Reset, synchronous, effective the next edge:
  - Delay line all invalid; FSM IDLE; accumulators 0.
  - res_valid=0, res_hit=0, res_count=0, res_first_id=0, overflow=0, lasts_in_flight=0.
  - issue_ready=1 combinationally after reset.
  - Reset mid-ray discards all in-flight boxes; hit_miss is ignored until new issues retire.
- overflow clears only on rst.

Optional Feature:
- Macro: RAY_AABB_ERROR_COUNT_EN.
- When defined:
  - Adds inputs exp_valid (1) and exp_hit (1): the high-precision reference bit, presented aligned with issue.
  - exp_hit travels in the delay line beside the tag.
  - On every valid head retire, with hit_miss != exp_hit:
    - Increment type1_err (16-bit out) when exp_hit=1 (missed true hit).
    - Increment type2_err (16-bit out) when exp_hit=0 (false hit).
  - Both counters saturate and reset to 0.
- When undefined: no extra ports or registers; behaviour above is unchanged.

Test Plan:
- Single ray, ids 0..3, last on id 3, core hit pattern 0,1,0,1 -> exactly one res_valid pulse, 34 cycles after the id-3 issue edge plus 1; res_hit=1, res_count=2, res_first_id=1.
- Ray of 5 boxes, all hit_miss=0 -> res_hit=0, res_count=0, res_first_id=0.
- Back-to-back single-box rays, ids 7 and 8, both hit, res_ready held 0 -> first result held; issue_ready=0 while the id-8 last is in flight (if it still issues, overflow=1 and the slot still shows id 7); then res_ready=1 drains it -> res_valid=0.
- CNT_W=2, ray of 6 boxes, all hit -> res_count=3 (saturated), res_first_id = first id.
- rst asserted 10 cycles after issuing a 4-box ray, core forced hit_miss=1 -> no result ever appears, overflow=0, issue_ready=1.
- RAY_AABB_ERROR_COUNT_EN: 10 boxes, exp_hit=1010101010, core 1000001011 -> type1_err=2, type2_err=1.
